// File: rtl/cache_miss_ctrl_if.sv
// Command, datapath-lookup and memory-side signals of the cache miss controller.
// The controller connects through the slave modport; its environment through master.
interface cache_miss_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_hit;
    logic              resp_wb;
    logic              tag_lookup;
    logic [ADDR_W-1:0] lkp_addr;
    logic              tag_hit;
    logic              victim_dirty;
    logic [ADDR_W-1:0] victim_addr;
    logic              tag_update;
    logic              upd_dirty;
    logic              tag_inval;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_write;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;

    modport slave (
        input  req_valid, req_type, req_addr, tag_hit, victim_dirty, victim_addr,
               mem_req_ready, mem_resp_valid,
        output req_ready, resp_valid, resp_hit, resp_wb, tag_lookup, lkp_addr,
               tag_update, upd_dirty, tag_inval, mem_req_valid, mem_req_write, mem_req_addr
    );

    modport master (
        output req_valid, req_type, req_addr, tag_hit, victim_dirty, victim_addr,
               mem_req_ready, mem_resp_valid,
        input  req_ready, resp_valid, resp_hit, resp_wb, tag_lookup, lkp_addr,
               tag_update, upd_dirty, tag_inval, mem_req_valid, mem_req_write, mem_req_addr
    );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Cache miss sequencer: tag lookup, writeback/fill handshakes, install/invalidate
// strobes and hit/miss/writeback statistics. All outputs are registered.
module cache_miss_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int LINE_SIZE = 64
) (
    input  logic             clk,
    input  logic             rst,
    cache_miss_ctrl_if.slave bus,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count,
    output logic [31:0]      wb_count
);
    localparam int OFFSET_W = $clog2(LINE_SIZE);
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, UPDATE, RESP
    } state_t;

    state_t            state_reg;
    logic [1:0]        type_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              req_ready_reg;
    logic              resp_valid_reg;
    logic              hit_reg;
    logic              wb_reg;
    logic              tag_lookup_reg;
    logic              tag_update_reg;
    logic              upd_dirty_reg;
    logic              tag_inval_reg;
    logic              mem_valid_reg;
    logic              mem_write_reg;
    logic [ADDR_W-1:0] mem_addr_reg;

    logic is_inval;
    logic is_write;
    assign is_inval = type_reg[1];       // types 2 and 3 both invalidate
    assign is_write = (type_reg == 2'd1);

    // Counter increment requests: [0]=hit, [1]=miss, [2]=writeback.
    logic [2:0] cnt_inc;
    always_comb begin
        cnt_inc = '0;
        if (state_reg == LOOKUP && !is_inval) begin
            cnt_inc[0] = bus.tag_hit;
            cnt_inc[1] = !bus.tag_hit;
        end
        cnt_inc[2] = (state_reg == WB_WAIT) && bus.mem_resp_valid;
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [31:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    cnt_reg <= '0;
                else if (cnt_inc[gi])
                    cnt_reg <= cnt_reg + 32'd1;
            end
        end
    endgenerate

    assign hit_count  = g_cnt[0].cnt_reg;
    assign miss_count = g_cnt[1].cnt_reg;
    assign wb_count   = g_cnt[2].cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            type_reg       <= '0;
            addr_reg       <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            hit_reg        <= 1'b0;
            wb_reg         <= 1'b0;
            tag_lookup_reg <= 1'b0;
            tag_update_reg <= 1'b0;
            upd_dirty_reg  <= 1'b0;
            tag_inval_reg  <= 1'b0;
            mem_valid_reg  <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
        end else begin
            tag_lookup_reg <= 1'b0;
            tag_update_reg <= 1'b0;
            upd_dirty_reg  <= 1'b0;
            tag_inval_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid && req_ready_reg) begin
                        type_reg       <= bus.req_type;
                        addr_reg       <= bus.req_addr;
                        req_ready_reg  <= 1'b0;
                        tag_lookup_reg <= 1'b1;
                        hit_reg        <= 1'b0;
                        wb_reg         <= 1'b0;
                        state_reg      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_reg <= bus.tag_hit;
                    if (bus.tag_hit && is_inval) begin
                        tag_inval_reg <= 1'b1;
                        state_reg     <= UPDATE;
                    end else if (bus.tag_hit && is_write) begin
                        tag_update_reg <= 1'b1;
                        upd_dirty_reg  <= 1'b1;
                        state_reg      <= UPDATE;
                    end else if (bus.tag_hit || is_inval) begin
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                    end else if (bus.victim_dirty) begin
                        mem_valid_reg <= 1'b1;
                        mem_write_reg <= 1'b1;
                        mem_addr_reg  <= bus.victim_addr & LINE_MASK;
                        state_reg     <= WB_REQ;
                    end else begin
                        mem_valid_reg <= 1'b1;
                        mem_write_reg <= 1'b0;
                        mem_addr_reg  <= addr_reg & LINE_MASK;
                        state_reg     <= FILL_REQ;
                    end
                end
                WB_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_valid_reg <= 1'b0;
                        state_reg     <= WB_WAIT;
                    end
                end
                WB_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        wb_reg        <= 1'b1;
                        mem_valid_reg <= 1'b1;
                        mem_write_reg <= 1'b0;
                        mem_addr_reg  <= addr_reg & LINE_MASK;
                        state_reg     <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_valid_reg <= 1'b0;
                        state_reg     <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        tag_update_reg <= 1'b1;
                        upd_dirty_reg  <= is_write;
                        state_reg      <= UPDATE;
                    end
                end
                UPDATE: begin
                    resp_valid_reg <= 1'b1;
                    state_reg      <= RESP;
                end
                RESP: begin
                    req_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_reg;
    assign bus.resp_valid    = resp_valid_reg;
    assign bus.resp_hit      = hit_reg;
    assign bus.resp_wb       = wb_reg;
    assign bus.tag_lookup    = tag_lookup_reg;
    assign bus.lkp_addr      = addr_reg;
    assign bus.tag_update    = tag_update_reg;
    assign bus.upd_dirty     = upd_dirty_reg;
    assign bus.tag_inval     = tag_inval_reg;
    assign bus.mem_req_valid = mem_valid_reg;
    assign bus.mem_req_write = mem_write_reg;
    assign bus.mem_req_addr  = mem_addr_reg;
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: directed and randomized commands against a
// transaction-level model, with a per-cycle protocol monitor.
module tb_cache_miss_ctrl;
    localparam int ADDR_W    = 32;
    localparam int LINE_SIZE = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] hit_count, miss_count, wb_count;

    cache_miss_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    cache_miss_ctrl #(.ADDR_W(ADDR_W), .LINE_SIZE(LINE_SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Monitor-recorded facts about the transaction in flight.
    bit          busy = 0, acc_seen = 0, resp_seen = 0, m_out = 0;
    int          acc_cyc = -10, resp_cyc = 0, first_mreq_cyc = -1, last_mresp_cyc = 0;
    int          upd_cyc = 0, inv_cyc = 0, n_upd = 0, n_inv = 0;
    bit          upd_dirty_seen = 0, resp_hit_seen = 0, resp_wb_seen = 0;
    logic [31:0] acc_addr = '0;
    logic [31:0] snap_hit = '0, snap_miss = '0, snap_wb = '0;
    bit          mreq_w_q[$];
    logic [31:0] mreq_a_q[$];
    bit          pv = 0, pr = 0, pw = 0;
    logic [31:0] pa = '0;

    // Memory responder knobs and model counters.
    bit          mem_auto = 1;
    int          mem_rdy_fix = -1, mem_rsp_fix = -1, m_phase = 0, m_cnt = 0;
    int unsigned m_hit = 0, m_miss = 0, m_wb = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] line_of(input logic [31:0] x);
        return x - (x % LINE_SIZE);
    endfunction

    function automatic int pick(input int fix);
        return (fix >= 0) ? fix : int'($urandom_range(0, 4));
    endfunction

    // Per-cycle monitor, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                busy  = 0;
                m_out = 0;
                pv    = 0;
            end else begin
                chk("req_ready", bus.req_ready, !busy);
                chk("tag_lookup", bus.tag_lookup, busy && (cyc == acc_cyc + 1));
                if (bus.tag_lookup) chk("lkp_addr", bus.lkp_addr, acc_addr);
                if (!busy)
                    chk("idle_quiet", {bus.resp_valid, bus.tag_update, bus.tag_inval, bus.mem_req_valid}, 4'b0);
                if (pv && !pr)
                    chk("mem_hold", {bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr}, {1'b1, pw, pa});
                if (m_out && !bus.mem_req_valid && bus.mem_resp_valid) begin
                    last_mresp_cyc = cyc;
                    m_out = 0;
                end
                if (bus.mem_req_valid) begin
                    chk("mem_align", bus.mem_req_addr % LINE_SIZE, 0);
                    if (first_mreq_cyc < 0) first_mreq_cyc = cyc;
                    if (bus.mem_req_ready) begin
                        mreq_w_q.push_back(bus.mem_req_write);
                        mreq_a_q.push_back(bus.mem_req_addr);
                        m_out = 1;
                    end
                end
                if (bus.tag_update) begin
                    n_upd++;
                    upd_cyc = cyc;
                    upd_dirty_seen = bus.upd_dirty;
                end
                if (bus.tag_inval) begin
                    n_inv++;
                    inv_cyc = cyc;
                end
                if (bus.resp_valid) begin
                    resp_cyc      = cyc;
                    resp_hit_seen = bus.resp_hit;
                    resp_wb_seen  = bus.resp_wb;
                    snap_hit      = hit_count;
                    snap_miss     = miss_count;
                    snap_wb       = wb_count;
                    resp_seen     = 1;
                    busy          = 0;
                end
                if (bus.req_valid && bus.req_ready) begin
                    busy = 1; acc_seen = 1; acc_cyc = cyc; acc_addr = bus.req_addr;
                    first_mreq_cyc = -1; n_upd = 0; n_inv = 0;
                    mreq_w_q.delete(); mreq_a_q.delete();
                end
                pv = bus.mem_req_valid; pr = bus.mem_req_ready;
                pw = bus.mem_req_write; pa = bus.mem_req_addr;
            end
        end
    end

    // Memory side: random grant delay, random completion delay, stray completions.
    initial begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!mem_auto) continue;
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            case (m_phase)
                0: begin
                    if (bus.mem_req_valid) begin
                        m_cnt = pick(mem_rdy_fix);
                        if (m_cnt == 0) begin
                            bus.mem_req_ready = 1'b1;
                            m_cnt = pick(mem_rsp_fix);
                            m_phase = 2;
                        end else m_phase = 1;
                    end else if ($urandom_range(0, 5) == 0) bus.mem_resp_valid = 1'b1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        bus.mem_req_ready = 1'b1;
                        m_cnt = pick(mem_rsp_fix);
                        m_phase = 2;
                    end
                end
                default: begin
                    if (m_cnt == 0) begin
                        bus.mem_resp_valid = 1'b1;
                        m_phase = 0;
                    end else m_cnt--;
                end
            endcase
        end
    end

    // Issue one command (called at posedge+1 with the DUT idle) and check it.
    task automatic run_txn(input logic [1:0] t, input logic [31:0] a, input bit h,
                           input bit d, input logic [31:0] va, input bit keep);
        bit inval, wr, exp_wb;
        int n, exp_nmem;
        inval  = t[1];
        wr     = (t == 2'd1);
        exp_wb = !inval && !h && d;
        exp_nmem = (inval || h) ? 0 : (exp_wb ? 2 : 1);
        if (!inval) begin
            if (h) m_hit++;
            else   m_miss++;
        end
        if (exp_wb) m_wb++;
        acc_seen = 0;
        resp_seen = 0;
        bus.req_type = t; bus.req_addr = a; bus.tag_hit = h;
        bus.victim_dirty = d; bus.victim_addr = va; bus.req_valid = 1'b1;
        n = 0;
        while (!acc_seen && n < 50) begin @(posedge clk); #1; n++; end
        if (!acc_seen) begin
            chk("accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        if (!keep) bus.req_valid = 1'b0;
        n = 0;
        while (!resp_seen && n < 400) begin @(posedge clk); #1; n++; end
        if (!resp_seen) begin
            chk("resp_timeout", 0, 1);
            return;
        end
        $display("txn type=%0d addr=%08h hit=%0d dirty=%0d -> resp_hit=%0d resp_wb=%0d lat=%0d",
                 t, a, h, d, resp_hit_seen, resp_wb_seen, resp_cyc - acc_cyc);
        chk("resp_hit", resp_hit_seen, h);
        chk("resp_wb", resp_wb_seen, exp_wb);
        chk("hit_count", snap_hit, m_hit);
        chk("miss_count", snap_miss, m_miss);
        chk("wb_count", snap_wb, m_wb);
        chk("mem_req_num", mreq_a_q.size(), exp_nmem);
        chk("tag_update_num", n_upd, (!inval && (!h || wr)) ? 1 : 0);
        chk("tag_inval_num", n_inv, (inval && h) ? 1 : 0);
        if (n_upd == 1) chk("upd_dirty", upd_dirty_seen, wr);
        if (mreq_a_q.size() == exp_nmem && exp_nmem > 0) begin
            if (exp_wb) begin
                chk("wb_write", mreq_w_q[0], 1);
                chk("wb_addr", mreq_a_q[0], line_of(va));
            end
            chk("fill_write", mreq_w_q[exp_nmem-1], 0);
            chk("fill_addr", mreq_a_q[exp_nmem-1], line_of(a));
        end
        if (inval || h) begin
            chk("hit_latency", resp_cyc - acc_cyc, (h && (wr || inval)) ? 3 : 2);
            if (h && wr)    chk("upd_cycle", upd_cyc - acc_cyc, 2);
            if (h && inval) chk("inval_cycle", inv_cyc - acc_cyc, 2);
        end else begin
            chk("first_mem_cycle", first_mreq_cyc - acc_cyc, 2);
            chk("miss_upd_cycle", upd_cyc - last_mresp_cyc, 1);
            chk("miss_resp_cycle", resp_cyc - last_mresp_cyc, 2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last_resp;
        bit keep, keep_prev;
        bus.req_valid = 1'b0; bus.req_type = '0; bus.req_addr = '0;
        bus.tag_hit = 1'b0; bus.victim_dirty = 1'b0; bus.victim_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_ready", bus.req_ready, 1);
        chk("reset_counters", {hit_count, miss_count, wb_count}, 96'h0);
        chk("reset_resp", bus.resp_valid, 0);

        // Read hit.
        run_txn(2'd0, 32'h0000_1040, 1, 0, 32'h0, 0);
        chk("t1_hit_count", hit_count, 1);
        chk("t1_latency", resp_cyc - acc_cyc, 2);
        chk("t1_no_mem", mreq_a_q.size(), 0);

        // Write miss, clean victim.
        mem_rdy_fix = 0; mem_rsp_fix = 3;
        run_txn(2'd1, 32'h0000_2044, 0, 0, 32'h0, 0);
        if (mreq_a_q.size() > 0) chk("t2_fill_addr", mreq_a_q[0], 32'h0000_2040);
        chk("t2_miss_count", miss_count, 1);
        chk("t2_wb_count", wb_count, 0);
        chk("t2_upd_dirty", upd_dirty_seen, 1);

        // Read miss, dirty victim, slow grant.
        mem_rdy_fix = 4; mem_rsp_fix = -1;
        run_txn(2'd0, 32'h0000_3010, 0, 1, 32'h0000_8000, 0);
        if (mreq_a_q.size() > 0) chk("t3_wb_addr", mreq_a_q[0], 32'h0000_8000);
        chk("t3_wb_count", wb_count, 1);
        chk("t3_resp_wb", resp_wb_seen, 1);

        // Invalidate a dirty hitting line.
        mem_rdy_fix = -1;
        run_txn(2'd2, 32'h0000_1040, 1, 1, 32'h0000_1040, 0);
        chk("t4_counters", {hit_count, miss_count, wb_count}, {32'd1, 32'd2, 32'd1});
        chk("t4_inval", n_inv, 1);

        // Back-to-back with req_valid held high.
        run_txn(2'd0, 32'h0000_0040, 1, 0, 32'h0, 1);
        last_resp = resp_cyc;
        run_txn(2'd3, 32'h0000_0080, 0, 0, 32'h0, 0);
        chk("b2b_accept", acc_cyc, last_resp + 1);

        // Randomized commands.
        keep_prev = 0;
        for (int i = 0; i < 80; i++) begin
            keep = ($urandom_range(0, 2) == 0);
            run_txn(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom, keep);
            if (keep_prev) chk("b2b_random", acc_cyc, last_resp + 1);
            keep_prev = keep;
            last_resp = resp_cyc;
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;

        // Reset during FILL_WAIT, then a late memory completion.
        mem_auto = 0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        bus.req_type = 2'd0; bus.req_addr = 32'h0000_5000;
        bus.tag_hit = 1'b0; bus.victim_dirty = 1'b0; bus.req_valid = 1'b1;
        acc_seen = 0;
        n = 0;
        while (!acc_seen && n < 20) begin @(posedge clk); #1; n++; end
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.mem_req_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("rst_fill_req", bus.mem_req_valid, 1);
        bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready = 1'b0;
        m_miss++;
        chk("rst_pre_miss", miss_count, m_miss);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hit = 0; m_miss = 0; m_wb = 0;
        bus.mem_resp_valid = 1'b1;
        @(posedge clk); #1;
        bus.mem_resp_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_counters", {hit_count, miss_count, wb_count}, 96'h0);
        m_phase = 0;
        mem_auto = 1;

        // Operation resumes after reset.
        run_txn(2'd1, 32'h0000_6000, 1, 0, 32'h0, 0);
        chk("post_rst_hit", hit_count, 1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
Sequencing controller in front of the set-associative cache tag/state datapath. It accepts one trace command at a time (read, write or invalidate), drives the tag lookup, and decides hit, miss, eviction and writeback. It runs the memory-side writeback and fill handshakes, then issues the install/update strobe back to the datapath. It also keeps the hit, miss and writeback statistics the simulator reports at end of trace.

Parameters:
ADDR_W, 32, address width in bits
LINE_SIZE, 64, line size in bytes; power of 2, 32..128; OFFSET_W = $clog2(LINE_SIZE)

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous, active-high reset
req_valid  in  1  command present
req_ready  out  1  controller can accept a command
req_type  in  2  0=read, 1=write, 2=invalidate, 3=reserved (treated as invalidate)
req_addr  in  ADDR_W  byte address
resp_valid  out  1  one-cycle completion pulse
resp_hit  out  1  command hit; valid with resp_valid
resp_wb  out  1  a dirty victim was written back; valid with resp_valid
tag_lookup  out  1  lookup strobe to datapath; high for the whole LOOKUP cycle
lkp_addr  out  ADDR_W  captured request address
tag_hit  in  1  combinational lookup result, sampled in LOOKUP
victim_dirty  in  1  chosen replacement way is valid and dirty; 0 if the way is empty
victim_addr  in  ADDR_W  line address of the victim
tag_update  out  1  one-cycle strobe: install line on miss, or set dirty on write hit
upd_dirty  out  1  dirty value for tag_update (1 for writes)
tag_inval  out  1  one-cycle strobe: clear the valid and dirty bits of the hitting way
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  1=writeback, 0=fill
mem_req_addr  out  ADDR_W  line-aligned address; low OFFSET_W bits forced to 0
mem_resp_valid  in  1  memory completion of the outstanding request
hit_count, miss_count, wb_count  out  32 each  statistics counters

Behaviour:
- States: IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, UPDATE, RESP.
- Reset (rst sampled high at a posedge):
  - State goes to IDLE; all strobes, mem_req_valid and resp_* go to 0.
  - All three counters clear to 0.
  - Applies mid-operation; the outstanding memory transaction is abandoned.
  - A mem_resp_valid arriving afterward is ignored.
- IDLE: req_ready=1 (only in IDLE). On req_valid&req_ready, capture type/addr and go to LOOKUP.
- LOOKUP (1 cycle): tag_lookup=1 and lkp_addr=captured address. Sample tag_hit, victim_dirty and victim_addr. Next state:
  - read hit -> RESP; hit_count++.
  - write hit -> UPDATE with upd_dirty=1; hit_count++.
  - read or write miss -> miss_count++. If victim_dirty: latch victim_addr and go to WB_REQ. Otherwise go to FILL_REQ.
  - invalidate hit -> pulse tag_inval in the next cycle, then RESP. No writeback (dirty data is discarded) and no counter change.
  - invalidate miss -> RESP.
- WB_REQ: mem_req_valid=1, mem_req_write=1, mem_req_addr=victim line address. Hold until mem_req_ready, then go to WB_WAIT.
- WB_WAIT: on mem_resp_valid, wb_count++, set resp_wb, go to FILL_REQ.
- FILL_REQ: same handshake with mem_req_write=0 and the request line address. FILL_WAIT: on mem_resp_valid go to UPDATE.
- UPDATE (1 cycle): tag_update=1. upd_dirty=1 for writes (write-allocate), 0 for reads. Then go to RESP.
- RESP (1 cycle): resp_valid=1 with resp_hit and resp_wb, then IDLE. No response backpressure.
- mem_req_valid must not drop before mem_req_ready is seen. mem_resp_valid outside WB_WAIT/FILL_WAIT is ignored.
- Latency from the accept edge: read hit resp at +2 cycles; write hit +3; clean miss = 4 + memory handshake cycles.
- Next command can be accepted no earlier than the cycle after RESP.
- Counters wrap modulo 2^32.

Test Plan:
- Reset, then read 0x0000_1040 with tag_hit=1 -> tag_lookup at cycle 1, resp_valid at cycle 2, resp_hit=1, hit_count=1, no mem_req_valid.
- Write 0x0000_2044, tag_hit=0, victim_dirty=0, mem_req_ready=1, mem_resp_valid 3 cycles later -> single fill at mem_req_addr=0x0000_2040, tag_update with upd_dirty=1, resp_hit=0, miss_count=1, wb_count=0.
- Read miss, victim_dirty=1, victim_addr=0x0000_8000, mem_req_ready low 4 cycles -> mem_req_valid held stable; writeback to 0x0000_8000 precedes fill; resp_wb=1, wb_count=1.
- Invalidate 0x0000_1040 with tag_hit=1 and a dirty line -> tag_inval pulse, no memory request, counters unchanged, resp_hit=1.
- Assert rst during FILL_WAIT, then pulse mem_resp_valid -> IDLE with req_ready=1, counters 0, no tag_update and no resp_valid.
- Back-to-back commands with req_valid held high -> second accepted the cycle after RESP; req_ready=0 in every other cycle.
